// File: rtl/md5_ctrl_pkg.sv
// md5_ctrl_pkg: shared FSM encoding, padding constants and byte-swap helper for md5_stream_ctrl
package md5_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, INIT, FILL, PAD, SEND_WAIT, SEND, DONE_WAIT} state_t;
    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         BLOCK_WORDS = 16;
    localparam int         LEN_WORD_LO = 14;
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/md5_pad_word.sv
// md5_pad_word: keeps the first nbytes bytes of data, puts PAD_BYTE at byte nbytes and zeros above
// Ports: data (32, little-endian message word), nbytes (3, valid bytes 0..4, >=4 keeps all), word (32, padded word)
module md5_pad_word
    import md5_ctrl_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [31:0] word
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word[8*b +: 8] = (3'(b) < nbytes) ? data[8*b +: 8] : (3'(b) == nbytes) ? PAD_BYTE : 8'h00;
    end
endmodule

// File: rtl/md5_stream_ctrl.sv
// md5_stream_ctrl: buffers a 32-bit word stream into 16-word blocks, applies MD5 padding and drives the md5sum core
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_data/in_last/in_bytes message stream;
//        core_rst_n/core_rdy/core_write_en/core_msg/core_done/core_a..d md5sum core handshake;
//        digest/digest_valid final result pulse; busy while a message is in flight.
// Option: define MD5_CTRL_DIGEST_BE_EN to byte-reverse each digest word into canonical hex order.
module md5_stream_ctrl
    import md5_ctrl_pkg::*;
#(
    parameter int LEN_W       = 32,
    parameter int INIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         core_rst_n,
    input  logic         core_rdy,
    output logic         core_write_en,
    output logic [31:0]  core_msg,
    input  logic         core_done,
    input  logic [31:0]  core_a,
    input  logic [31:0]  core_b,
    input  logic [31:0]  core_c,
    input  logic [31:0]  core_d,
    output logic [127:0] digest,
    output logic         digest_valid,
    output logic         busy
);
    state_t            state, state_n;
    logic [31:0]       blk [BLOCK_WORDS];
    logic [3:0]        wptr, init_cnt, send_cnt, w;
    logic [LEN_W-1:0]  byte_cnt;
    logic [4:0]        pad_idx;
    logic              got_last, final_blk, need_len, pad80_next, hs;
    logic [2:0]        k;
    logic [31:0]       pad_word;
    logic [63:0]       bit_len;
    logic [127:0]      dig_next;

    assign hs         = in_valid & in_ready;
    assign k          = (!in_last || in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign w          = (state == IDLE) ? 4'd0 : wptr;
    assign bit_len    = 64'(byte_cnt) << 3;
    assign core_rst_n = rst_n & (state != INIT);
`ifdef MD5_CTRL_DIGEST_BE_EN
    assign dig_next = {bswap32(core_a), bswap32(core_b), bswap32(core_c), bswap32(core_d)};
`else
    assign dig_next = {core_a, core_b, core_c, core_d};
`endif

    md5_pad_word u_pad (.data(in_data), .nbytes(k), .word(pad_word));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (hs) state_n = INIT;
            INIT:      if (init_cnt == 4'(INIT_CYCLES - 1)) state_n = got_last ? PAD : FILL;
            FILL:      if (hs) state_n = in_last ? PAD : (wptr == 4'd15) ? SEND_WAIT : FILL;
            PAD:       state_n = SEND_WAIT;
            SEND_WAIT: if (core_rdy) state_n = SEND;
            SEND:      if (send_cnt == 4'd0) state_n = DONE_WAIT;
            DONE_WAIT: if (core_done) state_n = final_blk ? IDLE : need_len ? PAD : FILL;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLOCK_WORDS; i++) blk[i] <= '0;
            in_ready      <= 1'b0;
            core_write_en <= 1'b0;
            core_msg      <= '0;
            digest        <= '0;
            digest_valid  <= 1'b0;
            busy          <= 1'b0;
            wptr          <= '0;
            init_cnt      <= '0;
            send_cnt      <= '0;
            byte_cnt      <= '0;
            pad_idx       <= '0;
            got_last      <= 1'b0;
            final_blk     <= 1'b0;
            need_len      <= 1'b0;
            pad80_next    <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            in_ready     <= (state_n == IDLE) || (state_n == FILL);
            if (hs) begin
                blk[w]   <= pad_word;
                wptr     <= w + 4'd1;
                byte_cnt <= ((state == IDLE) ? '0 : byte_cnt) + LEN_W'(k);
                // A full last word pushes the pad byte into the following word (or the next block at w=15)
                if (in_last && k == 3'd4 && w != 4'd15) blk[w + 4'd1] <= {24'h0, PAD_BYTE};
                pad_idx  <= {1'b0, w} + 5'(k == 3'd4);
                if (state == IDLE) begin
                    busy       <= 1'b1;
                    got_last   <= in_last;
                    final_blk  <= 1'b0;
                    need_len   <= 1'b0;
                    pad80_next <= 1'b0;
                    init_cnt   <= '0;
                end
            end
            if (state == INIT) init_cnt <= init_cnt + 4'd1;
            if (state == PAD) begin
                if (need_len || pad_idx < 5'(LEN_WORD_LO)) begin
                    blk[LEN_WORD_LO]     <= bit_len[31:0];
                    blk[LEN_WORD_LO + 1] <= bit_len[63:32];
                    if (pad80_next) blk[0] <= {24'h0, PAD_BYTE};
                    final_blk <= 1'b1;
                    need_len  <= 1'b0;
                end else begin
                    // No room for the length: send this block, build a length-only block afterwards
                    need_len   <= 1'b1;
                    pad80_next <= pad_idx[4];
                end
            end
            if (state == SEND_WAIT && core_rdy) begin
                core_write_en <= 1'b1;
                core_msg      <= blk[0];
                send_cnt      <= 4'd1;
            end
            if (state == SEND) begin
                core_write_en <= send_cnt != 4'd0;
                core_msg      <= (send_cnt != 4'd0) ? blk[send_cnt] : '0;
                send_cnt      <= send_cnt + 4'd1;
            end
            if (state == DONE_WAIT && core_done) begin
                for (int i = 0; i < BLOCK_WORDS; i++) blk[i] <= '0;
                wptr <= '0;
                if (final_blk) begin
                    digest       <= dig_next;
                    digest_valid <= 1'b1;
                    busy         <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_md5_stream_ctrl.sv
// tb_md5_stream_ctrl: directed bench with a behavioural md5sum-core stand-in that captures blocks and returns fixed chaining values
module tb_md5_stream_ctrl;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [31:0]  in_data = '0;
    logic [2:0]   in_bytes = '0;
    logic         core_rst_n, rdy_en = 1'b1, core_write_en, core_done = 1'b0;
    logic [31:0]  core_msg, core_a = '0, core_b = '0, core_c = '0, core_d = '0;
    logic [127:0] digest;
    logic         digest_valid, busy;

    int tests = 0, fails = 0;
    logic [31:0] cap [64];
    int cap_n = 0, we_total = 0, we_rises = 0, dv_count = 0, init_low = 0, wblk = 0, done_timer = 0;
    logic we_prev = 1'b0;

    md5_stream_ctrl #(.LEN_W(32), .INIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes), .core_rst_n(core_rst_n), .core_rdy(rdy_en),
        .core_write_en(core_write_en), .core_msg(core_msg), .core_done(core_done),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
        .digest(digest), .digest_valid(digest_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted, got no summary, want completion");
        $fatal(1);
    end

    // Core stand-in: records every written word, answers each 16-word block with core_done 3 cycles later
    initial begin
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (!core_rst_n) begin
                wblk = 0;
                done_timer = 0;
                if (rst_n) init_low++;
            end
            if (core_write_en) begin
                if (!we_prev) we_rises++;
                we_total++;
                if (cap_n < 64) cap[cap_n] = core_msg;
                cap_n++;
                wblk++;
                if (wblk == 16) begin
                    wblk = 0;
                    done_timer = 3;
                end
            end else if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) core_done = 1'b1;
            end
            we_prev = core_write_en;
            if (digest_valid) dv_count++;
        end
    end

    function automatic logic [31:0] sw(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [127:0] exp_dig(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
`ifdef MD5_CTRL_DIGEST_BE_EN
        return {sw(a), sw(b), sw(c), sw(d)};
`else
        return {a, b, c, d};
`endif
    endfunction

    task automatic clr_obs();
        cap_n = 0; we_total = 0; we_rises = 0; init_low = 0; dv_count = 0;
        for (int i = 0; i < 64; i++) cap[i] = '0;
    endtask

    task automatic set_core(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        core_a = a; core_b = b; core_c = c; core_d = d;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_word: in_ready got %b, want 1 within 500 cycles", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_dv(output bit ok);
        int t = 0;
        while (!digest_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = digest_valid;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, core_write_en, core_rst_n, digest_valid, busy} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctl: {rdy,we,core_rst_n,dv,busy} got %b, want 00000",
                     {in_ready, core_write_en, core_rst_n, digest_valid, busy});
        end
        tests++;
        if (core_msg !== 32'h0 || digest !== 128'h0) begin
            fails++;
            $display("FAIL reset_data: core_msg %h digest %h, want all zero", core_msg, digest);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || core_rst_n !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: in_ready %b core_rst_n %b, want 1 1", in_ready, core_rst_n);
        end
    endtask

    task automatic test_hello();
        logic [31:0] e [16];
        bit ok;
        logic [127:0] want;
`ifdef MD5_CTRL_DIGEST_BE_EN
        want = 128'h5d41402abc4b2a76b9719d911017c592;
`else
        want = 128'h2a40415d762a4bbc919d71b992c51710;
`endif
        for (int i = 0; i < 16; i++) e[i] = '0;
        e[0] = 32'h6C6C6568; e[1] = 32'h0000806F; e[14] = 32'h28;
        clr_obs();
        set_core(32'h2a40415d, 32'h762a4bbc, 32'h919d71b9, 32'h92c51710);
        send_word(32'h6C6C6568, 1'b0, 3'd4);
        send_word(32'h0000006F, 1'b1, 3'd1);
        wait_dv(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL hello_dv: digest_valid got 0, want pulse"); end
        tests++;
        if (digest !== want) begin fails++; $display("FAIL hello_digest: got %h, want %h", digest, want); end
        tests++;
        if (cap_n !== 16 || init_low !== 2) begin
            fails++;
            $display("FAIL hello_counts: words %0d init_low %0d, want 16 2", cap_n, init_low);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (cap[i] !== e[i]) begin fails++; $display("FAIL hello_blk[%0d]: got %h, want %h", i, cap[i], e[i]); end
        end
        @(negedge clk);
        tests++;
        if (digest_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hello_pulse: dv %b busy %b one cycle later, want 0 0", digest_valid, busy);
        end
    endtask

    task automatic test_empty();
        bit ok;
        clr_obs();
        set_core(32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec);
        send_word(32'h0, 1'b1, 3'd0);
        wait_dv(ok);
        tests++;
        if (!ok || digest !== exp_dig(32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec)) begin
            fails++; $display("FAIL empty_digest: ok %b got %h", ok, digest);
        end
        tests++;
        if (cap_n !== 16) begin fails++; $display("FAIL empty_words: got %0d, want 16", cap_n); end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (cap[i] !== ((i == 0) ? 32'h80 : 32'h0)) begin
                fails++; $display("FAIL empty_blk[%0d]: got %h, want %h", i, cap[i], (i == 0) ? 32'h80 : 32'h0);
            end
        end
    endtask

    task automatic test_boundary_55();
        logic [31:0] e [16];
        bit ok;
        for (int i = 0; i < 16; i++) e[i] = (i < 13) ? 32'h61616161 : 32'h0;
        e[13] = 32'h80616161; e[14] = 32'h1B8;
        clr_obs();
        set_core(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        for (int i = 0; i < 14; i++) begin
            send_word((i == 13) ? 32'h00616161 : 32'h61616161, i == 13, (i == 13) ? 3'd3 : 3'd4);
            if (i % 2 == 1) @(negedge clk);
        end
        wait_dv(ok);
        tests++;
        if (!ok || digest !== exp_dig(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444)) begin
            fails++; $display("FAIL b55_digest: ok %b got %h", ok, digest);
        end
        tests++;
        if (cap_n !== 16) begin fails++; $display("FAIL b55_words: got %0d, want 16", cap_n); end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (cap[i] !== e[i]) begin fails++; $display("FAIL b55_blk[%0d]: got %h, want %h", i, cap[i], e[i]); end
        end
    endtask

    task automatic test_two_block_56();
        logic [31:0] e [32];
        bit ok;
        for (int i = 0; i < 32; i++) e[i] = (i < 14) ? 32'h61616161 : 32'h0;
        e[14] = 32'h80; e[30] = 32'h1C0;
        clr_obs();
        set_core(32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4);
        for (int i = 0; i < 14; i++) send_word(32'h61616161, i == 13, 3'd4);
        wait_dv(ok);
        tests++;
        if (!ok || digest !== exp_dig(32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4)) begin
            fails++; $display("FAIL a56_digest: ok %b got %h", ok, digest);
        end
        tests++;
        if (cap_n !== 32 || dv_count !== 1) begin
            fails++; $display("FAIL a56_counts: words %0d dv %0d, want 32 1", cap_n, dv_count);
        end
        for (int i = 0; i < 32; i++) begin
            tests++;
            if (cap[i] !== e[i]) begin fails++; $display("FAIL a56_blk[%0d]: got %h, want %h", i, cap[i], e[i]); end
        end
    endtask

    task automatic test_full_64();
        logic [31:0] e [32];
        bit ok;
        for (int i = 0; i < 32; i++) e[i] = (i < 16) ? 32'h61616161 : 32'h0;
        e[16] = 32'h80; e[30] = 32'h200;
        clr_obs();
        set_core(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
        for (int i = 0; i < 16; i++) send_word(32'h61616161, i == 15, 3'd4);
        wait_dv(ok);
        tests++;
        if (!ok || digest !== exp_dig(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10)) begin
            fails++; $display("FAIL a64_digest: ok %b got %h", ok, digest);
        end
        tests++;
        if (cap_n !== 32) begin fails++; $display("FAIL a64_words: got %0d, want 32", cap_n); end
        for (int i = 0; i < 32; i++) begin
            tests++;
            if (cap[i] !== e[i]) begin fails++; $display("FAIL a64_blk[%0d]: got %h, want %h", i, cap[i], e[i]); end
        end
    endtask

    task automatic test_abc_backpressure();
        bit ok;
        int we_seen = 0;
        rdy_en = 1'b0;
        clr_obs();
        set_core(32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128);
        @(negedge clk);
        send_word(32'h00636261, 1'b1, 3'd3);
        repeat (50) begin
            @(negedge clk);
            we_seen += int'(core_write_en);
        end
        tests++;
        if (we_seen !== 0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL abc_hold: we cycles %0d busy %b in_ready %b, want 0 1 0", we_seen, busy, in_ready);
        end
        rdy_en = 1'b1;
        wait_dv(ok);
        tests++;
        if (!ok || digest !== exp_dig(32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128)) begin
            fails++; $display("FAIL abc_digest: ok %b got %h", ok, digest);
        end
        tests++;
        if (we_total !== 16 || we_rises !== 1) begin
            fails++; $display("FAIL abc_burst: we cycles %0d bursts %0d, want 16 1", we_total, we_rises);
        end
        tests++;
        if (cap[0] !== 32'h80636261 || cap[14] !== 32'h18 || cap[15] !== 32'h0) begin
            fails++; $display("FAIL abc_blk: w0 %h w14 %h w15 %h, want 80636261 00000018 00000000", cap[0], cap[14], cap[15]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t = 0;
        clr_obs();
        set_core(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        for (int i = 0; i < 14; i++) send_word(32'h61616161, i == 13, 3'd4);
        while (cap_n < 3 && t < 500) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (cap_n < 3) begin fails++; $display("FAIL rstmid_send: words seen %0d, want >=3", cap_n); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, core_write_en, core_rst_n, digest_valid, busy} !== 5'b0 || core_msg !== 32'h0 || digest !== 128'h0) begin
            fails++;
            $display("FAIL rstmid_outputs: ctl %b msg %h digest %h, want zeros",
                     {in_ready, core_write_en, core_rst_n, digest_valid, busy}, core_msg, digest);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clr_obs();
        set_core(32'h2a40415d, 32'h762a4bbc, 32'h919d71b9, 32'h92c51710);
        send_word(32'h6C6C6568, 1'b0, 3'd4);
        send_word(32'h0000006F, 1'b1, 3'd1);
        wait_dv(ok);
        tests++;
        if (!ok || digest !== exp_dig(32'h2a40415d, 32'h762a4bbc, 32'h919d71b9, 32'h92c51710)) begin
            fails++; $display("FAIL rstmid_digest: ok %b got %h", ok, digest);
        end
        repeat (100) @(negedge clk);
        tests++;
        if (dv_count !== 1 || cap_n !== 16 || cap[1] !== 32'h0000806F || cap[14] !== 32'h28) begin
            fails++;
            $display("FAIL rstmid_after: dv %0d words %0d w1 %h w14 %h, want 1 16 0000806f 00000028",
                     dv_count, cap_n, cap[1], cap[14]);
        end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_empty();
        test_boundary_55();
        test_two_block_56();
        test_full_64();
        test_abc_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
